// File: rtl/ram_ctrl.sv
// Single-port RAM controller: host read/write requests plus a whole-memory fill.
// The RAM data bus is shared; the controller drives it only on write strobes.
module ram_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  input  logic        fill_start,
  input  logic [31:0] fill_value,
  output logic        fill_done,
  output logic        en_write,
  output logic        en_read,
  output logic [7:0]  addr_ram_out,
  inout  wire  [31:0] data_ram_io
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    RSP  = 3'd4,
    FILL = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] fill_q, fill_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic [31:0] bus_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= 8'd0;
      cnt_q   <= 8'd0;
      wdata_q <= 32'd0;
      fill_q  <= 32'd0;
      rdata_q <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      fill_q  <= fill_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    fill_d  = fill_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // A fill request outranks a pending host request in the same cycle.
        if (fill_start) begin
          fill_d  = fill_value;
          cnt_d   = 8'd0;
          state_d = FILL;
        end else if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = req_we ? WR : RD1;
        end
      end
      WR:  state_d = IDLE;
      RD1: state_d = RD2;
      RD2: begin
        rdata_d = data_ram_io;
        state_d = RSP;
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      FILL: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'hFF) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are gated by rst_n so an asserted reset aborts the current access at once.
  assign req_ready = rst_n && (state_q == IDLE) && !fill_start;
  assign en_write  = rst_n && ((state_q == WR) || (state_q == FILL));
  assign en_read   = rst_n && ((state_q == RD1) || (state_q == RD2));
  assign rsp_valid = rst_n && (state_q == RSP);
  assign fill_done = rst_n && done_q;
  assign rsp_rdata = rdata_q;

  always_comb begin
    addr_ram_out = 8'd0;
    case (state_q)
      WR, RD1, RD2: addr_ram_out = addr_q;
      FILL:         addr_ram_out = cnt_q;
      default:      addr_ram_out = 8'd0;
    endcase
  end

  assign bus_out     = (state_q == FILL) ? fill_q : wdata_q;
  assign data_ram_io = en_write ? bus_out : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl with a behavioural 256x32 RAM on the shared bus.
module tb_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, rsp_ready, fill_start;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata, fill_value;
  logic        req_ready, rsp_valid, fill_done, en_write, en_read;
  logic [31:0] rsp_rdata;
  logic [7:0]  addr_ram_out;
  wire  [31:0] data_ram_io;

  logic [31:0] mem [256];
  logic        init_done = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          viol = 0;

  ram_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .fill_start(fill_start), .fill_value(fill_value), .fill_done(fill_done),
    .en_write(en_write), .en_read(en_read), .addr_ram_out(addr_ram_out),
    .data_ram_io(data_ram_io)
  );

  always #5 clk = ~clk;

  // RAM model: asynchronous read onto the bus, write on the rising edge.
  assign data_ram_io = en_read ? mem[addr_ram_out] : 32'hzzzz_zzzz;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 | i;
    end else if (en_write) begin
      mem[addr_ram_out] <= data_ram_io;
    end
  end

  always @(negedge clk) begin
    if (init_done) begin
      if (en_write && en_read) viol++;
      if (en_read && (data_ram_io !== mem[addr_ram_out])) viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    #1;
    check("wr_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check("wr_en_write", 32'(en_write), 32'd1);
    check("wr_en_read", 32'(en_read), 32'd0);
    check("wr_addr", 32'(addr_ram_out), 32'(a));
    check("wr_bus", data_ram_io, d);
    tick();
    check("wr_done_en", 32'(en_write), 32'd0);
    check("wr_no_rsp", 32'(rsp_valid), 32'd0);
  endtask

  task automatic do_read(input string tag, input logic [7:0] a, input logic [31:0] exp, input int hold);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    rsp_ready = (hold == 0);
    tick();
    req_valid = 1'b0;
    check({tag, "_rd1_en"}, 32'(en_read), 32'd1);
    check({tag, "_rd1_addr"}, 32'(addr_ram_out), 32'(a));
    check({tag, "_rd1_vld"}, 32'(rsp_valid), 32'd0);
    tick();
    check({tag, "_rd2_en"}, 32'(en_read), 32'd1);
    check({tag, "_rd2_vld"}, 32'(rsp_valid), 32'd0);
    tick();
    check({tag, "_rsp_vld"}, 32'(rsp_valid), 32'd1);
    check({tag, "_rsp_en_read"}, 32'(en_read), 32'd0);
    check({tag, "_rsp_data"}, rsp_rdata, exp);
    for (int i = 0; i < hold; i++) begin
      fill_start = (i == 2);
      fill_value = 32'hFFFF_0000;
      #1;
      check({tag, "_hold_vld"}, 32'(rsp_valid), 32'd1);
      check({tag, "_hold_data"}, rsp_rdata, exp);
      check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
      tick();
    end
    fill_start = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check({tag, "_pre_rel_vld"}, 32'(rsp_valid), 32'd1);
    tick();
    check({tag, "_rel_vld"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rel_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_kept_data"}, rsp_rdata, exp);
    tick();
    check({tag, "_no_fill"}, 32'(en_write), 32'd0);
  endtask

  initial begin
    int bad;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'd0;
    req_wdata = 32'd0; rsp_ready = 1'b0; fill_start = 1'b0; fill_value = 32'd0;
    tick();
    init_done = 1'b1;
    tick();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_vld", 32'(rsp_valid), 32'd0);
    check("rst_en_write", 32'(en_write), 32'd0);
    check("rst_en_read", 32'(en_read), 32'd0);
    check("rst_addr", 32'(addr_ram_out), 32'd0);
    check("rst_fill_done", 32'(fill_done), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);
    tick();

    do_write(8'h3C, 32'hDEAD_BEEF);
    do_read("rd3c", 8'h3C, 32'hDEAD_BEEF, 0);
    do_read("rd10", 8'h10, 32'h1000_0010, 5);

    // Fill and a read request raised together: fill wins.
    fill_start = 1'b1; fill_value = 32'hA5A5_A5A5;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h05; rsp_ready = 1'b1;
    #1;
    check("fill_prio_ready", 32'(req_ready), 32'd0);
    tick();
    fill_start = 1'b0;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (!en_write || en_read || fill_done || req_ready ||
          (addr_ram_out != 8'(i)) || (data_ram_io != 32'hA5A5_A5A5)) bad++;
      tick();
    end
    check("fill_cycles_bad", 32'(bad), 32'd0);
    check("fill_done_pulse", 32'(fill_done), 32'd1);
    check("fill_end_en_write", 32'(en_write), 32'd0);
    check("fill_end_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check("fill_done_single", 32'(fill_done), 32'd0);
    check("post_fill_accept", 32'(en_read), 32'd1);
    check("post_fill_addr", 32'(addr_ram_out), 32'h05);
    tick();
    tick();
    check("post_fill_vld", 32'(rsp_valid), 32'd1);
    check("post_fill_data", rsp_rdata, 32'hA5A5_A5A5);
    tick();
    tick();
    do_read("rd00", 8'h00, 32'hA5A5_A5A5, 0);
    do_read("rdff", 8'hFF, 32'hA5A5_A5A5, 0);

    // Reset pulse in the middle of a fill.
    fill_start = 1'b1; fill_value = 32'h1234_5678;
    tick();
    fill_start = 1'b0;
    repeat (128) tick();
    check("mid_fill_addr", 32'(addr_ram_out), 32'h80);
    check("mid_fill_en", 32'(en_write), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_fill_en_during", 32'(en_write), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_fill_en_after", 32'(en_write), 32'd0);
    check("rst_fill_addr", 32'(addr_ram_out), 32'd0);
    check("rst_fill_rdata", rsp_rdata, 32'd0);
    check("rst_fill_ready", 32'(req_ready), 32'd1);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (fill_done || en_write) bad++;
      tick();
    end
    check("rst_fill_no_done", 32'(bad), 32'd0);
    do_read("rd7f", 8'h7F, 32'h1234_5678, 0);
    do_read("rd81", 8'h81, 32'hA5A5_A5A5, 0);

    check("bus_exclusive", 32'(viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 The block SHALL have no parameters: data width fixed at 32 bits, address width fixed at 8 bits, depth 256 words.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  1  host request present.
REQ-005 req_ready  output  1  controller can accept a request this cycle.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  8  word address.
REQ-008 req_wdata  input  32  write data.
REQ-009 rsp_valid  output  1  read data available.
REQ-010 rsp_ready  input  1  host accepts read data.
REQ-011 rsp_rdata  output  32  read data.
REQ-012 fill_start  input  1  start whole-memory fill.
REQ-013 fill_value  input  32  fill word, sampled with fill_start.
REQ-014 fill_done  output  1  one-cycle pulse at end of fill.
REQ-015 en_write  output  1  RAM write strobe.
REQ-016 en_read  output  1  RAM read strobe.
REQ-017 addr_ram_out  output  8  RAM address.
REQ-018 data_ram_io  inout  32  shared RAM data bus; driven by controller only while en_write=1, else high-Z.

Function
REQ-019 FSM states SHALL be IDLE, WR, RD1, RD2, RSP, FILL; encoding free.
REQ-020 req_ready SHALL be 1 only in IDLE with fill_start=0; handshake completes on an edge with req_valid=1 and req_ready=1.
REQ-021 On accept, req_addr/req_we/req_wdata SHALL be latched; next state WR if req_we=1, else RD1.
REQ-022 In IDLE, fill_start=1 SHALL take priority over req_valid: latch fill_value, clear fill counter to 0, go to FILL.
REQ-023 WR: en_write=1, en_read=0, addr_ram_out=latched address, bus driven with latched data; next IDLE (2 cycles per write incl. accept cycle); writes SHALL produce no response.
REQ-024 RD1: en_read=1, addr_ram_out=latched address, bus high-Z; next RD2.
REQ-025 RD2: en_read=1, same address, bus high-Z; rsp_rdata SHALL capture data_ram_io at the end of RD2; next RSP.
REQ-026 RSP: rsp_valid=1, rsp_rdata stable, en_read=0; on rsp_ready=1 go to IDLE, else hold indefinitely.
REQ-027 rsp_valid SHALL first assert 3 cycles after the accept edge; rsp_rdata SHALL keep its value after RSP until the next capture.
REQ-028 FILL: en_write=1, addr_ram_out=counter, bus driven with latched fill_value; counter increments by 1 each cycle (8-bit).
REQ-029 Fill SHALL end after the cycle writing address 255 (256 cycles total, no wrap-around write to 0): fill_done=1 for exactly that cycle's successor (first IDLE cycle), then IDLE.
REQ-030 req_valid, fill_start and rsp_ready SHALL be ignored in states where they have no effect; fill_start during a transaction SHALL be dropped, not queued.
REQ-031 en_write and en_read SHALL never be 1 in the same cycle; the controller SHALL never drive the bus while en_read=1.
REQ-032 All outputs except data_ram_io SHALL be registered or decoded from state only (no combinational path from req_* to RAM-side pins).

Reset
REQ-033 On any edge with rst_n=0: state IDLE, fill counter 0, rsp_rdata 0, latched request 0.
REQ-034 During and after reset: req_ready=0 while rst_n=0, rsp_valid=0, fill_done=0, en_write=0, en_read=0, addr_ram_out=0, bus high-Z.
REQ-035 Reset mid-write, mid-read or mid-fill SHALL abort immediately; no response or fill_done SHALL be produced for the aborted operation.

Verification
REQ-036 Write 0xDEADBEEF to 0x3C, then read 0x3C with rsp_ready=1 -> en_write one cycle with addr 0x3C; rsp_valid 3 cycles after read accept with rsp_rdata=0xDEADBEEF.
REQ-037 Read 0x10 with rsp_ready=0 for 5 cycles -> rsp_valid held, rsp_rdata stable, req_ready=0 until rsp_ready=1 edge.
REQ-038 fill_start with fill_value=0xA5A5A5A5 -> 256 consecutive en_write cycles, addresses 0..255, fill_done single pulse; reads of 0x00 and 0xFF return 0xA5A5A5A5.
REQ-039 fill_start and req_valid asserted together in IDLE -> fill wins, req_ready=0, request accepted only after fill_done.
REQ-040 rst_n low for 1 cycle at fill address 0x80 -> en_write=0 next cycle, no fill_done, req_ready=1 after reset release.
REQ-041 Checker across all tests: en_write&en_read never both 1; data_ram_io never driven by controller while en_read=1.
